// File: rtl/pipe_stage_reg.sv
// Pipeline inter-stage register for the D/E/M/W boundaries of the MIPS pipeline.
// Supports stall (hold), bubble (NOP keeping PC/BD), flush, Tnew decrement and stall/bubble counters.
module pipe_stage_reg #(
    parameter int          DATA_W   = 64,
    parameter int          CTRL_W   = 24,
    parameter int          TNEW_W   = 2,
    parameter int          TNEW_DEC = 1,
    parameter int          EXC_W    = 5,
    parameter logic [31:0] PC_RST   = 32'h0000_3000,
    parameter int          CNT_W    = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush_i,
    input  logic              stall_i,
    input  logic              bubble_i,
    input  logic              cnt_clr_i,
    input  logic              in_valid,
    input  logic [31:0]       in_pc,
    input  logic [31:0]       in_instr,
    input  logic [DATA_W-1:0] in_data,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [TNEW_W-1:0] in_tnew,
    input  logic [4:0]        in_a3,
    input  logic [EXC_W-1:0]  in_exc,
    input  logic              in_bd,
    output logic              out_valid,
    output logic [31:0]       out_pc,
    output logic [31:0]       out_instr,
    output logic [DATA_W-1:0] out_data,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [TNEW_W-1:0] out_tnew,
    output logic [4:0]        out_a3,
    output logic [EXC_W-1:0]  out_exc,
    output logic              out_bd,
    output logic              out_exc_pend,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  bubble_cnt
);

    logic [TNEW_W-1:0] tnew_next;

    // Comparison is done at full integer width so a large TNEW_DEC still saturates instead of wrapping.
    always_comb begin
        tnew_next = '0;
        if (32'(in_tnew) > 32'(TNEW_DEC))
            tnew_next = in_tnew - TNEW_DEC[TNEW_W-1:0];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid  <= 1'b0;
            out_pc     <= PC_RST;
            out_instr  <= '0;
            out_data   <= '0;
            out_ctrl   <= '0;
            out_tnew   <= '0;
            out_a3     <= '0;
            out_exc    <= '0;
            out_bd     <= 1'b0;
            stall_cnt  <= '0;
            bubble_cnt <= '0;
        end else begin
            if (flush_i) begin
                out_valid <= 1'b0;
                out_pc    <= PC_RST;
                out_instr <= '0;
                out_data  <= '0;
                out_ctrl  <= '0;
                out_tnew  <= '0;
                out_a3    <= '0;
                out_exc   <= '0;
                out_bd    <= 1'b0;
            end else if (stall_i) begin
                out_valid <= out_valid;
            end else if (bubble_i) begin
                out_valid <= 1'b0;
                out_pc    <= in_pc;
                out_instr <= '0;
                out_data  <= '0;
                out_ctrl  <= '0;
                out_tnew  <= '0;
                out_a3    <= '0;
                out_exc   <= '0;
                out_bd    <= in_bd;
            end else begin
                out_valid <= in_valid;
                out_pc    <= in_pc;
                out_instr <= in_instr;
                out_data  <= in_data;
                out_ctrl  <= in_ctrl;
                out_tnew  <= tnew_next;
                out_a3    <= in_a3;
                out_exc   <= in_valid ? in_exc : '0;
                out_bd    <= in_bd;
            end

            // A clear wins over any increment requested in the same cycle.
            if (cnt_clr_i) begin
                stall_cnt  <= '0;
                bubble_cnt <= '0;
            end else if (!flush_i) begin
                if (stall_i) begin
                    if (stall_cnt != '1)
                        stall_cnt <= stall_cnt + 1'b1;
                end else if (bubble_i) begin
                    if (bubble_cnt != '1)
                        bubble_cnt <= bubble_cnt + 1'b1;
                end
            end
        end
    end

    assign out_exc_pend = out_valid && (out_exc != '0);

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Scoreboard bench for pipe_stage_reg: one default instance and one with TNEW_DEC=0 and 2-bit counters.
module tb_pipe_stage_reg;

    logic        clk;
    logic        reset, flush_i, stall_i, bubble_i, cnt_clr_i;
    logic        in_valid, in_bd;
    logic [31:0] in_pc, in_instr;
    logic [63:0] in_data;
    logic [23:0] in_ctrl;
    logic [1:0]  in_tnew;
    logic [4:0]  in_a3, in_exc;

    logic        a_valid, a_bd, a_pend;
    logic [31:0] a_pc, a_instr;
    logic [63:0] a_data;
    logic [23:0] a_ctrl;
    logic [1:0]  a_tnew;
    logic [4:0]  a_a3, a_exc;
    logic [15:0] a_scnt, a_bcnt;

    logic        b_valid, b_bd, b_pend;
    logic [31:0] b_pc, b_instr;
    logic [63:0] b_data;
    logic [23:0] b_ctrl;
    logic [1:0]  b_tnew;
    logic [4:0]  b_a3, b_exc;
    logic [1:0]  b_scnt, b_bcnt;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        valid;
        logic [31:0] pc, instr;
        logic [63:0] data;
        logic [23:0] ctrl;
        logic [1:0]  tnew, tnew0;
        logic [4:0]  a3, exc;
        logic        bd;
        logic [15:0] scnt, bcnt;
        logic [1:0]  scnt_b, bcnt_b;
    } exp_t;

    exp_t model;
    exp_t sb[$];

    pipe_stage_reg dut_a (
        .clk(clk), .reset(reset), .flush_i(flush_i), .stall_i(stall_i), .bubble_i(bubble_i),
        .cnt_clr_i(cnt_clr_i), .in_valid(in_valid), .in_pc(in_pc), .in_instr(in_instr),
        .in_data(in_data), .in_ctrl(in_ctrl), .in_tnew(in_tnew), .in_a3(in_a3), .in_exc(in_exc),
        .in_bd(in_bd), .out_valid(a_valid), .out_pc(a_pc), .out_instr(a_instr), .out_data(a_data),
        .out_ctrl(a_ctrl), .out_tnew(a_tnew), .out_a3(a_a3), .out_exc(a_exc), .out_bd(a_bd),
        .out_exc_pend(a_pend), .stall_cnt(a_scnt), .bubble_cnt(a_bcnt)
    );

    pipe_stage_reg #(.TNEW_DEC(0), .CNT_W(2)) dut_b (
        .clk(clk), .reset(reset), .flush_i(flush_i), .stall_i(stall_i), .bubble_i(bubble_i),
        .cnt_clr_i(cnt_clr_i), .in_valid(in_valid), .in_pc(in_pc), .in_instr(in_instr),
        .in_data(in_data), .in_ctrl(in_ctrl), .in_tnew(in_tnew), .in_a3(in_a3), .in_exc(in_exc),
        .in_bd(in_bd), .out_valid(b_valid), .out_pc(b_pc), .out_instr(b_instr), .out_data(b_data),
        .out_ctrl(b_ctrl), .out_tnew(b_tnew), .out_a3(b_a3), .out_exc(b_exc), .out_bd(b_bd),
        .out_exc_pend(b_pend), .stall_cnt(b_scnt), .bubble_cnt(b_bcnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic setPayload(input logic vld, input logic [31:0] pc, input logic [1:0] tnew,
                              input logic [4:0] a3, input logic [4:0] exc, input logic bd);
        in_valid = vld;
        in_pc    = pc;
        in_tnew  = tnew;
        in_a3    = a3;
        in_exc   = exc;
        in_bd    = bd;
        in_instr = $urandom();
        in_data  = {$urandom(), $urandom()};
        in_ctrl  = 24'($urandom());
    endtask

    // Drive the controls, predict the next register contents, clock once, then compare.
    task automatic applyStimulus(input logic rst, input logic fl, input logic st,
                                 input logic bu, input logic cc);
        exp_t n, e;
        reset = rst; flush_i = fl; stall_i = st; bubble_i = bu; cnt_clr_i = cc;
        n = model;
        if (rst) begin
            n = '{default: '0};
            n.pc = 32'h0000_3000;
        end else begin
            if (fl) begin
                n.valid = 0; n.pc = 32'h0000_3000; n.instr = 0; n.data = 0; n.ctrl = 0;
                n.tnew = 0; n.tnew0 = 0; n.a3 = 0; n.exc = 0; n.bd = 0;
            end else if (!st && bu) begin
                n.valid = 0; n.pc = in_pc; n.instr = 0; n.data = 0; n.ctrl = 0;
                n.tnew = 0; n.tnew0 = 0; n.a3 = 0; n.exc = 0; n.bd = in_bd;
            end else if (!st) begin
                n.valid = in_valid; n.pc = in_pc; n.instr = in_instr; n.data = in_data;
                n.ctrl = in_ctrl; n.a3 = in_a3; n.bd = in_bd;
                n.exc   = in_valid ? in_exc : 5'd0;
                n.tnew  = (in_tnew >= 2'd2) ? in_tnew - 2'd1 : 2'd0;
                n.tnew0 = in_tnew;
            end
            if (cc) begin
                n.scnt = 0; n.bcnt = 0; n.scnt_b = 0; n.bcnt_b = 0;
            end else if (!fl && st) begin
                if (model.scnt != 16'hFFFF) n.scnt = model.scnt + 16'd1;
                if (model.scnt_b != 2'd3)   n.scnt_b = model.scnt_b + 2'd1;
            end else if (!fl && bu) begin
                if (model.bcnt != 16'hFFFF) n.bcnt = model.bcnt + 16'd1;
                if (model.bcnt_b != 2'd3)   n.bcnt_b = model.bcnt_b + 2'd1;
            end
        end
        model = n;
        sb.push_back(n);
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            checkOutput("sb_empty", 64'd0, 64'd1);
        end else begin
            e = sb.pop_front();
            checkOutput("valid", 64'(a_valid), 64'(e.valid));
            checkOutput("pc",    64'(a_pc),    64'(e.pc));
            checkOutput("instr", 64'(a_instr), 64'(e.instr));
            checkOutput("data",  a_data,       e.data);
            checkOutput("ctrl",  64'(a_ctrl),  64'(e.ctrl));
            checkOutput("tnew",  64'(a_tnew),  64'(e.tnew));
            checkOutput("a3",    64'(a_a3),    64'(e.a3));
            checkOutput("exc",   64'(a_exc),   64'(e.exc));
            checkOutput("bd",    64'(a_bd),    64'(e.bd));
            checkOutput("pend",  64'(a_pend),  64'(e.valid && (e.exc != 5'd0)));
            checkOutput("scnt",  64'(a_scnt),  64'(e.scnt));
            checkOutput("bcnt",  64'(a_bcnt),  64'(e.bcnt));
            checkOutput("b_pc",    64'(b_pc),    64'(e.pc));
            checkOutput("b_valid", 64'(b_valid), 64'(e.valid));
            checkOutput("b_tnew",  64'(b_tnew),  64'(e.tnew0));
            checkOutput("b_scnt",  64'(b_scnt),  64'(e.scnt_b));
            checkOutput("b_bcnt",  64'(b_bcnt),  64'(e.bcnt_b));
        end
    endtask

    initial begin
        model = '{default: '0};
        setPayload(1'b1, 32'h1234, 2'd3, 5'd9, 5'd3, 1'b1);
        applyStimulus(1, 0, 0, 0, 0);
        applyStimulus(1, 0, 0, 0, 0);
        checkOutput("rst_pc",   64'(a_pc), 64'h3000);
        checkOutput("rst_data", a_data, 64'd0);

        $display("[TB] load and tnew decrement");
        setPayload(1'b1, 32'h3004, 2'd2, 5'd8, 5'd0, 1'b0);
        applyStimulus(0, 0, 0, 0, 0);
        checkOutput("load_tnew", 64'(a_tnew), 64'd1);
        checkOutput("load_a3",   64'(a_a3),   64'd8);
        setPayload(1'b1, 32'h3008, 2'd0, 5'd1, 5'd0, 1'b0);
        applyStimulus(0, 0, 0, 0, 0);
        checkOutput("tnew_sat0", 64'(a_tnew), 64'd0);
        setPayload(1'b1, 32'h300c, 2'd1, 5'd1, 5'd0, 1'b0);
        applyStimulus(0, 0, 0, 0, 0);
        checkOutput("tnew_sat1", 64'(a_tnew), 64'd0);
        setPayload(1'b1, 32'h300c, 2'd3, 5'd1, 5'd0, 1'b0);
        applyStimulus(0, 0, 0, 0, 0);
        checkOutput("tnew_dec0", 64'(b_tnew), 64'd3);

        $display("[TB] stall hold");
        setPayload(1'b1, 32'h3010, 2'd3, 5'd4, 5'd0, 1'b0);
        applyStimulus(0, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            setPayload(1'b0, 32'h4000 + 32'(i), 2'd0, 5'd7, 5'd2, 1'b1);
            applyStimulus(0, 0, 1, 0, 0);
            checkOutput("stall_pc", 64'(a_pc), 64'h3010);
        end
        checkOutput("stall_cnt3", 64'(a_scnt), 64'd3);

        $display("[TB] bubble");
        setPayload(1'b1, 32'h3020, 2'd2, 5'd5, 5'd4, 1'b1);
        applyStimulus(0, 0, 0, 1, 0);
        checkOutput("bub_pc",   64'(a_pc),   64'h3020);
        checkOutput("bub_bd",   64'(a_bd),   64'd1);
        checkOutput("bub_a3",   64'(a_a3),   64'd0);
        checkOutput("bub_cnt1", 64'(a_bcnt), 64'd1);

        $display("[TB] stall with bubble, counters to 7");
        for (int i = 0; i < 4; i++) begin
            setPayload(1'b1, 32'h5000, 2'd1, 5'd3, 5'd0, 1'b0);
            applyStimulus(0, 0, 1, 1, 0);
        end
        checkOutput("stall_cnt7", 64'(a_scnt), 64'd7);
        checkOutput("b_sat",      64'(b_scnt), 64'd3);
        applyStimulus(0, 1, 1, 0, 0);
        checkOutput("flush_pc",   64'(a_pc),   64'h3000);
        checkOutput("flush_cnt7", 64'(a_scnt), 64'd7);
        applyStimulus(0, 0, 1, 0, 1);
        checkOutput("clr_cnt",    64'(a_scnt), 64'd0);

        $display("[TB] exception gating");
        setPayload(1'b1, 32'h3030, 2'd0, 5'd2, 5'd12, 1'b0);
        applyStimulus(0, 0, 0, 0, 0);
        checkOutput("exc_pend1", 64'(a_pend), 64'd1);
        setPayload(1'b0, 32'h3034, 2'd0, 5'd2, 5'd12, 1'b0);
        applyStimulus(0, 0, 0, 0, 0);
        checkOutput("exc_gate", 64'(a_exc), 64'd0);

        $display("[TB] reset during stall");
        setPayload(1'b1, 32'h3040, 2'd3, 5'd6, 5'd1, 1'b1);
        applyStimulus(0, 0, 0, 0, 0);
        applyStimulus(0, 0, 1, 0, 0);
        applyStimulus(1, 0, 1, 0, 0);
        checkOutput("rst_stall_pc", 64'(a_pc), 64'h3000);

        $display("[TB] random traffic");
        for (int i = 0; i < 300; i++) begin
            setPayload(1'($urandom()), $urandom(), 2'($urandom()), 5'($urandom()),
                       5'($urandom_range(0, 3)), 1'($urandom()));
            applyStimulus(($urandom_range(0, 49) == 0), ($urandom_range(0, 9) == 0),
                          ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0),
                          ($urandom_range(0, 19) == 0));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
